// File: rtl/dvp_frame_capture.sv
// OV7670 DVP frame receiver: synchronises camera pins into i_clk, assembles
// 2-byte pixels and emits BRAM write strobes with (h,v) addresses.
module dvp_frame_capture #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned H_WIDTH     = 320,
   parameter int unsigned V_WIDTH     = 240,
   parameter int unsigned SYNC_STAGES = 3
) (
   input  logic                          i_clk,
   input  logic                          i_n_reset,
   input  logic [1:0]                    i_mode,
   input  logic                          i_continuous,
   input  logic                          i_start_capture,
   input  logic                          i_abort,
   input  logic                          i_PCLK,
   input  logic                          i_VS,
   input  logic                          i_HS,
   input  logic [DATA_WIDTH-1:0]         i_DATA,
   output logic [2*DATA_WIDTH-1:0]       o_pixel_data,
   output logic [$clog2(H_WIDTH)-1:0]    o_h_addr,
   output logic [$clog2(V_WIDTH)-1:0]    o_v_addr,
   output logic                          o_valid,
   output logic                          o_frame_done,
   output logic                          o_line_err,
   output logic                          o_busy,
   output logic [3:0]                    o_state
);

   localparam int unsigned HAW = $clog2(H_WIDTH);
   localparam int unsigned VAW = $clog2(V_WIDTH);
   localparam int unsigned HCW = $clog2(H_WIDTH + 1);
   localparam int unsigned VCW = $clog2(V_WIDTH + 1);
   localparam logic [HCW-1:0] H_MAX = HCW'(H_WIDTH);
   localparam logic [VCW-1:0] V_MAX = VCW'(V_WIDTH);

   // IDLE is all-zero so the debug state reads 0 out of reset
   typedef enum logic [3:0] {
      S_IDLE       = 4'b0000,
      S_WAIT_VS_HI = 4'b0001,
      S_WAIT_VS_LO = 4'b0010,
      S_ACTIVE     = 4'b0100,
      S_DONE       = 4'b1000
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [SYNC_STAGES-1:0]                 r_pclk_sync;
   logic [SYNC_STAGES-1:0]                 r_vs_sync;
   logic [SYNC_STAGES-1:0]                 r_hs_sync;
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_data_sync;
   logic                                   r_pclk_d;
   logic                                   r_vs_s;
   logic                                   r_hs_s;
   logic [1:0]                             r_mode;
   logic                                   r_phase;
   logic [DATA_WIDTH-1:0]                  r_byte0;
   logic [HCW-1:0]                         r_h;
   logic [VCW-1:0]                         r_v;

   logic                                   w_pclk_rise;
   logic                                   w_vs;
   logic                                   w_hs;
   logic [DATA_WIDTH-1:0]                  w_data;
   logic                                   w_vs_rise;
   logic                                   w_hs_fall;
   logic [2*DATA_WIDTH-1:0]                w_pixel;

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_pclk_sync <= '0;
         r_vs_sync   <= '0;
         r_hs_sync   <= '0;
         r_data_sync <= '0;
         r_pclk_d    <= 1'b0;
      end else begin
         r_pclk_sync <= {r_pclk_sync[SYNC_STAGES-2:0], i_PCLK};
         r_vs_sync   <= {r_vs_sync[SYNC_STAGES-2:0], i_VS};
         r_hs_sync   <= {r_hs_sync[SYNC_STAGES-2:0], i_HS};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_DATA};
         r_pclk_d    <= r_pclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_pclk_rise = r_pclk_sync[SYNC_STAGES-1] & ~r_pclk_d;
   assign w_vs        = r_vs_sync[SYNC_STAGES-1];
   assign w_hs        = r_hs_sync[SYNC_STAGES-1];
   assign w_data      = r_data_sync[SYNC_STAGES-1];
   assign w_vs_rise   = w_pclk_rise & w_vs & ~r_vs_s;
   assign w_hs_fall   = w_pclk_rise & ~w_hs & r_hs_s;

   always_comb begin
      w_pixel = {r_byte0, w_data};
      case (r_mode)
         2'b01:   w_pixel = {1'b0, r_byte0[DATA_WIDTH-2:0], w_data};
         2'b10:   w_pixel = {{(DATA_WIDTH/2){1'b0}}, r_byte0[DATA_WIDTH/2-1:0], w_data};
         default: w_pixel = {r_byte0, w_data};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) r_state <= S_IDLE;
      else            r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:       if (i_start_capture)      w_next_state = S_WAIT_VS_HI;
         S_WAIT_VS_HI: if (w_pclk_rise && w_vs)  w_next_state = S_WAIT_VS_LO;
         S_WAIT_VS_LO: if (w_pclk_rise && !w_vs) w_next_state = S_ACTIVE;
         S_ACTIVE:     if (w_vs_rise)            w_next_state = S_DONE;
         S_DONE:       w_next_state = i_continuous ? S_WAIT_VS_HI : S_IDLE;
         default:      w_next_state = S_IDLE;
      endcase
      if (i_abort) w_next_state = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_vs_s       <= 1'b0;
         r_hs_s       <= 1'b0;
         r_mode       <= 2'b00;
         r_phase      <= 1'b0;
         r_byte0      <= '0;
         r_h          <= '0;
         r_v          <= '0;
         o_pixel_data <= '0;
         o_h_addr     <= '0;
         o_v_addr     <= '0;
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
         o_line_err   <= 1'b0;
      end else begin
         o_valid      <= 1'b0;
         o_line_err   <= 1'b0;
         o_frame_done <= (w_next_state == S_DONE);
         if (w_pclk_rise) begin
            r_vs_s <= w_vs;
            r_hs_s <= w_hs;
         end
         if (r_state == S_IDLE && i_start_capture && !i_abort) r_mode <= i_mode;

         if (r_state != S_ACTIVE || i_abort) begin
            r_h     <= '0;
            r_v     <= '0;
            r_phase <= 1'b0;
         end else if (w_pclk_rise) begin
            // line-length check runs before a coincident VS rise clears the counters
            if (w_hs_fall && r_h != H_MAX && r_v < V_MAX) o_line_err <= 1'b1;
            if (w_vs_rise) begin
               r_h     <= '0;
               r_v     <= '0;
               r_phase <= 1'b0;
            end else if (w_hs_fall) begin
               r_phase <= 1'b0;
               r_h     <= '0;
               if (r_v < V_MAX) r_v <= r_v + 1'b1;
            end else if (w_hs) begin
               if (!r_phase) begin
                  r_byte0 <= w_data;
                  r_phase <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  if (r_h < H_MAX) begin
                     r_h <= r_h + 1'b1;
                     if (r_v < V_MAX) begin
                        o_valid      <= 1'b1;
                        o_pixel_data <= w_pixel;
                        o_h_addr     <= r_h[HAW-1:0];
                        o_v_addr     <= r_v[VAW-1:0];
                     end
                  end
               end
            end
         end
      end
   end

   assign o_busy  = (r_state != S_IDLE);
   assign o_state = r_state;

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Bench for dvp_frame_capture with a 4x4 frame: format vector table plus
// scripted frames; expected writes are queued as bytes are driven.
module tb_dvp_frame_capture;

   localparam int unsigned DW = 8;
   localparam int unsigned HW = 4;
   localparam int unsigned VW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        cont = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        pclk = 1'b0;
   logic        vs = 1'b0;
   logic        hs = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [15:0] pix;
   logic [1:0]  haddr;
   logic [1:0]  vaddr;
   logic        valid, fdone, lerr, busy;
   logic [3:0]  state;

   dvp_frame_capture #(
      .DATA_WIDTH (DW),
      .H_WIDTH    (HW),
      .V_WIDTH    (VW),
      .SYNC_STAGES(3)
   ) dut (
      .i_clk          (clk),
      .i_n_reset      (rst_n),
      .i_mode         (mode),
      .i_continuous   (cont),
      .i_start_capture(start),
      .i_abort        (abort),
      .i_PCLK         (pclk),
      .i_VS           (vs),
      .i_HS           (hs),
      .i_DATA         (data),
      .o_pixel_data   (pix),
      .o_h_addr       (haddr),
      .o_v_addr       (vaddr),
      .o_valid        (valid),
      .o_frame_done   (fdone),
      .o_line_err     (lerr),
      .o_busy         (busy),
      .o_state        (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pix;
      logic [1:0]  h;
      logic [1:0]  v;
   } exp_t;

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] exp;
   } vec_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned fd_cnt = 0;
   int unsigned le_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: got pix 0x%0h at (%0d,%0d) expected no write at %0t",
                        pix, haddr, vaddr, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pixel", {12'h000, pix, haddr, vaddr}, {12'h000, e});
            end
         end
         if (fdone) fd_cnt++;
         if (lerr)  le_cnt++;
      end
   end

   task automatic pclk_cyc(input logic v, input logic h, input logic [7:0] d);
      pclk = 1'b0; vs = v; hs = h; data = d;
      #40 pclk = 1'b1;
      #40;
   endtask

   task automatic vs_pulse();
      repeat (3) pclk_cyc(1'b1, 1'b0, 8'h00);
      repeat (3) pclk_cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_pixel(input int k, input int li, input logic armed,
                             input logic [7:0] a, input logic [7:0] b, input logic [15:0] ep);
      exp_t e;
      pclk_cyc(1'b0, 1'b1, a);
      if (armed && k < int'(HW) && li < int'(VW)) begin
         e.pix = ep; e.h = 2'(k); e.v = 2'(li);
         sb.push_back(e);
      end
      pclk_cyc(1'b0, 1'b1, b);
   endtask

   // fixed=0: 565 with bytes stepping per pixel; fixed=1: constant bytes, expected pixel fp
   task automatic send_line(input int n, input int li, input logic armed,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic fixed, input logic [15:0] fp);
      for (int k = 0; k < n; k++) begin
         logic [7:0] a, b;
         a = fixed ? b0 : b0 + 8'(k);
         b = fixed ? b1 : b1 + 8'(k);
         send_pixel(k, li, armed, a, b, fixed ? fp : {a, b});
      end
      repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic full_frame(input logic armed, input logic [7:0] seed);
      for (int li = 0; li < int'(VW); li++)
         send_line(int'(HW), li, armed, seed + 8'(4*li), seed + 8'h22 + 8'(4*li), 1'b0, 16'h0);
   endtask

   task automatic pulse_start();
      start = 1'b1; #10 start = 1'b0;
   endtask

   task automatic frame_check(input string tag, input int unsigned efd, input int unsigned ele);
      #200;
      chk({tag, "_drained"}, sb.size(), 0);
      chk({tag, "_frame_done"}, fd_cnt, efd);
      chk({tag, "_line_err"}, le_cnt, ele);
      chk({tag, "_state"}, {28'h0, state}, 0);
      chk({tag, "_busy"}, {31'h0, busy}, 0);
      sb.delete();
      fd_cnt = 0;
      le_cnt = 0;
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{2'b00, 8'h12, 8'h34, 16'h1234};
      vt[1] = '{2'b01, 8'hFF, 8'hAB, 16'h7FAB};
      vt[2] = '{2'b10, 8'hFF, 8'hAB, 16'h0FAB};
      vt[3] = '{2'b11, 8'hFF, 8'hAB, 16'hFFAB};
      vt[4] = '{2'b01, 8'h80, 8'h01, 16'h0001};
      vt[5] = '{2'b10, 8'h5A, 8'hC3, 16'h0AC3};
      vt[6] = '{2'b00, 8'hA5, 8'h5A, 16'hA55A};
      vt[7] = '{2'b01, 8'h7F, 8'hFF, 16'h7FFF};

      #22;
      chk("rst_valid", {31'h0, valid}, 0);
      chk("rst_frame_done", {31'h0, fdone}, 0);
      chk("rst_line_err", {31'h0, lerr}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_state", {28'h0, state}, 0);
      chk("rst_pixel", {16'h0, pix}, 0);
      chk("rst_addr", {28'h0, haddr, vaddr}, 0);
      rst_n = 1'b1;
      #20;

      // 565 4x4 frame, bytes 0x12,0x34 stepping
      mode = 2'b00;
      pulse_start();
      chk("armed_busy", {31'h0, busy}, 1);
      vs_pulse();
      for (int li = 0; li < 4; li++)
         send_line(4, li, 1'b1, 8'h12 + 8'(4*li), 8'h34 + 8'(4*li), 1'b0, 16'h0);
      vs_pulse();
      frame_check("f565", 1, 0);
      chk("hold_last", {12'h0, pix, haddr, vaddr}, {12'h0, 16'h2143, 2'd3, 2'd3});

      // format table; mode input is changed after arming to check it is latched
      for (int i = 0; i < 8; i++) begin
         mode = vt[i].mode;
         pulse_start();
         mode = ~vt[i].mode;
         vs_pulse();
         send_line(4, 0, 1'b1, vt[i].b0, vt[i].b1, 1'b1, vt[i].exp);
         vs_pulse();
         frame_check("fmt", 1, 0);
      end
      mode = 2'b00;

      // short line in the middle of a frame
      pulse_start();
      vs_pulse();
      send_line(4, 0, 1'b1, 8'h40, 8'h50, 1'b0, 16'h0);
      send_line(3, 1, 1'b1, 8'h44, 8'h54, 1'b0, 16'h0);
      send_line(4, 2, 1'b1, 8'h48, 8'h58, 1'b0, 16'h0);
      send_line(4, 3, 1'b1, 8'h4C, 8'h5C, 1'b0, 16'h0);
      vs_pulse();
      frame_check("short", 1, 1);

      // over-long line and extra line: dropped, no line error
      pulse_start();
      vs_pulse();
      send_line(6, 0, 1'b1, 8'h60, 8'h70, 1'b0, 16'h0);
      send_line(4, 1, 1'b1, 8'h64, 8'h74, 1'b0, 16'h0);
      send_line(4, 2, 1'b1, 8'h68, 8'h78, 1'b0, 16'h0);
      send_line(4, 3, 1'b1, 8'h6C, 8'h7C, 1'b0, 16'h0);
      send_line(3, 4, 1'b1, 8'h90, 8'h91, 1'b0, 16'h0);
      vs_pulse();
      frame_check("overflow", 1, 0);

      // continuous: three frames back to back
      cont = 1'b1;
      pulse_start();
      vs_pulse();
      full_frame(1'b1, 8'h01);
      vs_pulse();
      chk("cont_busy", {31'h0, busy}, 1);
      full_frame(1'b1, 8'h11);
      vs_pulse();
      full_frame(1'b1, 8'h21);
      cont = 1'b0;
      vs_pulse();
      frame_check("cont", 3, 0);

      // abort mid-line, then restart while VS already low
      pulse_start();
      vs_pulse();
      send_pixel(0, 0, 1'b1, 8'hC0, 8'hC1, 16'hC0C1);
      send_pixel(1, 0, 1'b1, 8'hC2, 8'hC3, 16'hC2C3);
      #80 abort = 1'b1;
      #10 abort = 1'b0;
      chk("abort_state", {28'h0, state}, 0);
      send_pixel(2, 0, 1'b0, 8'hC4, 8'hC5, 16'h0);
      send_pixel(3, 0, 1'b0, 8'hC6, 8'hC7, 16'h0);
      repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
      send_line(4, 1, 1'b0, 8'hD0, 8'hD1, 1'b0, 16'h0);
      frame_check("abort", 0, 0);
      pulse_start();
      send_line(4, 2, 1'b0, 8'hD4, 8'hD5, 1'b0, 16'h0);
      send_line(4, 3, 1'b0, 8'hD8, 8'hD9, 1'b0, 16'h0);
      vs_pulse();
      full_frame(1'b1, 8'h31);
      vs_pulse();
      frame_check("restart", 1, 0);

      // reset mid-frame, then a fresh capture
      pulse_start();
      vs_pulse();
      send_line(4, 0, 1'b1, 8'hE0, 8'hE4, 1'b0, 16'h0);
      rst_n = 1'b0;
      #20;
      chk("midrst_state", {28'h0, state}, 0);
      rst_n = 1'b1;
      #10;
      pulse_start();
      send_line(4, 1, 1'b0, 8'hE8, 8'hEC, 1'b0, 16'h0);
      vs_pulse();
      full_frame(1'b1, 8'h41);
      vs_pulse();
      frame_check("midrst", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
